// File: rtl/csa_accumulator_if.sv
// Handshake bundle for csa_accumulator: sample stream in, block result out.
// The environment drives the master side; the accumulator uses the slave side.
interface csa_accumulator_if #(
  parameter int unsigned WIDTH     = 12,
  parameter int unsigned ACC_WIDTH = 16
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_sum;
  logic                 in_cout;
  logic                 clear;
  logic                 out_valid;
  logic                 out_ready;
  logic [ACC_WIDTH-1:0] acc_out;
  logic                 ovf;
  logic [7:0]           count;

  modport master (
    output in_valid, in_sum, in_cout, clear, out_ready,
    input  in_ready, out_valid, acc_out, ovf, count
  );

  modport slave (
    input  in_valid, in_sum, in_cout, clear, out_ready,
    output in_ready, out_valid, acc_out, ovf, count
  );
endinterface

// File: rtl/csa_accumulator.sv
// Block accumulator for carry-select adder results: sums BLOCK_LEN samples, then holds the total.
// Define CSA_ACC_SAT_EN to saturate the accumulator on overflow instead of wrapping.
module csa_accumulator #(
  parameter int unsigned WIDTH     = 12,
  parameter int unsigned ACC_WIDTH = 16,
  parameter int unsigned BLOCK_LEN = 4
) (
  input logic              clk,
  input logic              rst,
  csa_accumulator_if.slave bus
);

  typedef enum logic [0:0] {StAcc, StDone} state_e;

  localparam logic [7:0] LastCount = 8'(BLOCK_LEN - 1);

  state_e               state_q;
  logic [ACC_WIDTH-1:0] acc_q;
  logic                 ovf_q;
  logic [7:0]           count_q;
  logic                 in_ready_q;
  logic                 out_valid_q;

  logic [ACC_WIDTH-1:0] value;
  logic [ACC_WIDTH:0]   sum_ext;
  logic                 carry;
  logic [ACC_WIDTH-1:0] acc_nxt;

  // The adder carry-out is the MSB of the sample, so the sample is WIDTH+1 bits wide.
  assign value = ACC_WIDTH'({bus.in_cout, bus.in_sum});

  always_comb begin
    sum_ext = {1'b0, acc_q} + {1'b0, value};
    carry   = sum_ext[ACC_WIDTH];
`ifdef CSA_ACC_SAT_EN
    // Once saturated, any further non-zero add carries again, so all-ones is sticky.
    acc_nxt = carry ? '1 : sum_ext[ACC_WIDTH-1:0];
`else
    acc_nxt = sum_ext[ACC_WIDTH-1:0];
`endif
  end

  always_ff @(posedge clk) begin
    if (rst || bus.clear) begin
      state_q     <= StAcc;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      count_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StAcc: begin
          if (bus.in_valid) begin
            acc_q   <= acc_nxt;
            ovf_q   <= ovf_q | carry;
            count_q <= count_q + 8'd1;
            if (count_q == LastCount) begin
              state_q     <= StDone;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end
          end
        end
        StDone: begin
          if (bus.out_ready) begin
            state_q     <= StAcc;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            count_q     <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= StAcc;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.acc_out   = acc_q;
  assign bus.ovf       = ovf_q;
  assign bus.count     = count_q;

endmodule

// File: tb/tb_csa_accumulator.sv
// Directed self-checking bench for csa_accumulator: default build on bus_a, ACC_WIDTH=14 on bus_b.
module tb_csa_accumulator;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   passes = 0;

  always #5 clk = ~clk;

  csa_accumulator_if #(.WIDTH(12), .ACC_WIDTH(16)) bus_a ();
  csa_accumulator_if #(.WIDTH(12), .ACC_WIDTH(14)) bus_b ();

  csa_accumulator #(.WIDTH(12), .ACC_WIDTH(16), .BLOCK_LEN(4)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a.slave)
  );

  csa_accumulator #(.WIDTH(12), .ACC_WIDTH(14), .BLOCK_LEN(4)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic v, input logic [11:0] s, input logic c);
    bus_a.in_valid = v;
    bus_a.in_sum   = s;
    bus_a.in_cout  = c;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (bus_a.in_ready !== 1'b1 || bus_a.out_valid !== 1'b0)
      $display("FAIL reset_hs: in_ready=%b out_valid=%b want 1 0", bus_a.in_ready,
               bus_a.out_valid);
    else passes++;
    checks++;
    if (bus_a.acc_out !== 16'h0 || bus_a.count !== 8'd0 || bus_a.ovf !== 1'b0)
      $display("FAIL reset_state: acc=%h count=%0d ovf=%b want 0 0 0", bus_a.acc_out,
               bus_a.count, bus_a.ovf);
    else passes++;
    rst = 1'b0;
  endtask

  // Four samples of 0x001 -> total 4, out_valid one cycle after the fourth accept.
  task automatic test_basic();
    for (int i = 0; i < 4; i++) begin
      drive_a(1'b1, 12'h001, 1'b0);
      tick();
      checks++;
      if (bus_a.acc_out !== 16'(i + 1) || bus_a.count !== 8'(i + 1) ||
          bus_a.out_valid !== (i == 3))
        $display("FAIL basic_step%0d: acc=%h count=%0d out_valid=%b want %h %0d %b", i,
                 bus_a.acc_out, bus_a.count, bus_a.out_valid, 16'(i + 1), i + 1, i == 3);
      else passes++;
    end
    drive_a(1'b0, 12'h000, 1'b0);
    checks++;
    if (bus_a.ovf !== 1'b0 || bus_a.in_ready !== 1'b0)
      $display("FAIL basic_done: ovf=%b in_ready=%b want 0 0", bus_a.ovf, bus_a.in_ready);
    else passes++;
  endtask

  // Held in DONE with offered input, then one-cycle handshake that must not accept.
  task automatic test_hold();
    drive_a(1'b1, 12'h123, 1'b0);
    bus_a.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (bus_a.out_valid !== 1'b1 || bus_a.acc_out !== 16'h0004 || bus_a.in_ready !== 1'b0 ||
          bus_a.count !== 8'd4)
        $display("FAIL hold_cyc%0d: out_valid=%b acc=%h in_ready=%b count=%0d want 1 0004 0 4",
                 i, bus_a.out_valid, bus_a.acc_out, bus_a.in_ready, bus_a.count);
      else passes++;
    end
    bus_a.out_ready = 1'b1;
    tick();
    bus_a.out_ready = 1'b0;
    drive_a(1'b0, 12'h000, 1'b0);
    checks++;
    if (bus_a.out_valid !== 1'b0 || bus_a.in_ready !== 1'b1 || bus_a.acc_out !== 16'h0 ||
        bus_a.count !== 8'd0)
      $display("FAIL hold_release: out_valid=%b in_ready=%b acc=%h count=%0d want 0 1 0 0",
               bus_a.out_valid, bus_a.in_ready, bus_a.acc_out, bus_a.count);
    else passes++;
  endtask

  // Largest sample 0x1FFF x4 = 0x7FFC, no overflow in 16 bits.
  task automatic test_max();
    for (int i = 0; i < 4; i++) begin
      drive_a(1'b1, 12'hFFF, 1'b1);
      tick();
    end
    drive_a(1'b0, 12'h000, 1'b0);
    checks++;
    if (bus_a.acc_out !== 16'h7FFC || bus_a.ovf !== 1'b0 || bus_a.out_valid !== 1'b1)
      $display("FAIL max_total: acc=%h ovf=%b out_valid=%b want 7ffc 0 1", bus_a.acc_out,
               bus_a.ovf, bus_a.out_valid);
    else passes++;
    bus_a.out_ready = 1'b1;
    tick();
    bus_a.out_ready = 1'b0;
  endtask

  task automatic test_clear();
    for (int i = 0; i < 2; i++) begin
      drive_a(1'b1, 12'h010, 1'b0);
      tick();
    end
    checks++;
    if (bus_a.acc_out !== 16'h0020 || bus_a.count !== 8'd2)
      $display("FAIL clear_pre: acc=%h count=%0d want 0020 2", bus_a.acc_out, bus_a.count);
    else passes++;
    bus_a.clear = 1'b1;
    tick();
    bus_a.clear = 1'b0;
    checks++;
    if (bus_a.acc_out !== 16'h0 || bus_a.count !== 8'd0 || bus_a.in_ready !== 1'b1)
      $display("FAIL clear_abort: acc=%h count=%0d in_ready=%b want 0 0 1", bus_a.acc_out,
               bus_a.count, bus_a.in_ready);
    else passes++;
    for (int i = 0; i < 3; i++) begin
      tick();
    end
    checks++;
    if (bus_a.out_valid !== 1'b0 || bus_a.acc_out !== 16'h0030 || bus_a.count !== 8'd3)
      $display("FAIL clear_three: out_valid=%b acc=%h count=%0d want 0 0030 3",
               bus_a.out_valid, bus_a.acc_out, bus_a.count);
    else passes++;
    tick();
    drive_a(1'b0, 12'h000, 1'b0);
    checks++;
    if (bus_a.out_valid !== 1'b1 || bus_a.acc_out !== 16'h0040)
      $display("FAIL clear_fresh: out_valid=%b acc=%h want 1 0040", bus_a.out_valid,
               bus_a.acc_out);
    else passes++;
    // Clear while DONE drops the result without a handshake.
    bus_a.clear = 1'b1;
    tick();
    bus_a.clear = 1'b0;
    checks++;
    if (bus_a.out_valid !== 1'b0 || bus_a.acc_out !== 16'h0 || bus_a.in_ready !== 1'b1)
      $display("FAIL clear_done: out_valid=%b acc=%h in_ready=%b want 0 0 1", bus_a.out_valid,
               bus_a.acc_out, bus_a.in_ready);
    else passes++;
  endtask

  task automatic test_rst_done();
    for (int i = 0; i < 4; i++) begin
      drive_a(1'b1, 12'h005, 1'b0);
      tick();
    end
    drive_a(1'b0, 12'h000, 1'b0);
    checks++;
    if (bus_a.out_valid !== 1'b1 || bus_a.acc_out !== 16'h0014)
      $display("FAIL rst_done_pre: out_valid=%b acc=%h want 1 0014", bus_a.out_valid,
               bus_a.acc_out);
    else passes++;
    rst = 1'b1;
    bus_a.out_ready = 1'b0;
    tick();
    rst = 1'b0;
    checks++;
    if (bus_a.out_valid !== 1'b0 || bus_a.acc_out !== 16'h0 || bus_a.in_ready !== 1'b1)
      $display("FAIL rst_done: out_valid=%b acc=%h in_ready=%b want 0 0 1", bus_a.out_valid,
               bus_a.acc_out, bus_a.in_ready);
    else passes++;
  endtask

  // ACC_WIDTH=14: 0x1FFF x4 overflows on the third add.
  task automatic test_ovf();
    logic [13:0] exp3;
    logic [13:0] exp4;
`ifdef CSA_ACC_SAT_EN
    exp3 = 14'h3FFF;
    exp4 = 14'h3FFF;
`else
    exp3 = 14'h1FFD;
    exp4 = 14'h3FFC;
`endif
    bus_b.in_valid = 1'b1;
    bus_b.in_sum   = 12'hFFF;
    bus_b.in_cout  = 1'b1;
    tick();
    tick();
    checks++;
    if (bus_b.acc_out !== 14'h3FFE || bus_b.ovf !== 1'b0)
      $display("FAIL ovf_two: acc=%h ovf=%b want 3ffe 0", bus_b.acc_out, bus_b.ovf);
    else passes++;
    tick();
    checks++;
    if (bus_b.acc_out !== exp3 || bus_b.ovf !== 1'b1)
      $display("FAIL ovf_three: acc=%h ovf=%b want %h 1", bus_b.acc_out, bus_b.ovf, exp3);
    else passes++;
    tick();
    bus_b.in_valid = 1'b0;
    checks++;
    if (bus_b.acc_out !== exp4 || bus_b.ovf !== 1'b1 || bus_b.out_valid !== 1'b1)
      $display("FAIL ovf_final: acc=%h ovf=%b out_valid=%b want %h 1 1", bus_b.acc_out,
               bus_b.ovf, bus_b.out_valid, exp4);
    else passes++;
    bus_b.out_ready = 1'b1;
    tick();
    bus_b.out_ready = 1'b0;
    checks++;
    if (bus_b.ovf !== 1'b0 || bus_b.acc_out !== 14'h0)
      $display("FAIL ovf_cleared: acc=%h ovf=%b want 0 0", bus_b.acc_out, bus_b.ovf);
    else passes++;
  endtask

  // in_valid and out_ready held high across two blocks; sample offered in the handshake drops.
  task automatic test_back_to_back();
    bus_a.out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      drive_a(1'b1, 12'(i), 1'b0);
      tick();
    end
    checks++;
    if (bus_a.out_valid !== 1'b1 || bus_a.acc_out !== 16'h000A)
      $display("FAIL b2b_first: out_valid=%b acc=%h want 1 000a", bus_a.out_valid,
               bus_a.acc_out);
    else passes++;
    drive_a(1'b1, 12'h009, 1'b0);
    tick();
    checks++;
    if (bus_a.in_ready !== 1'b1 || bus_a.acc_out !== 16'h0 || bus_a.count !== 8'd0)
      $display("FAIL b2b_handshake: in_ready=%b acc=%h count=%0d want 1 0 0", bus_a.in_ready,
               bus_a.acc_out, bus_a.count);
    else passes++;
    for (int i = 5; i <= 8; i++) begin
      drive_a(1'b1, 12'(i), 1'b0);
      tick();
    end
    drive_a(1'b0, 12'h000, 1'b0);
    checks++;
    if (bus_a.out_valid !== 1'b1 || bus_a.acc_out !== 16'h001A || bus_a.count !== 8'd4)
      $display("FAIL b2b_second: out_valid=%b acc=%h count=%0d want 1 001a 4", bus_a.out_valid,
               bus_a.acc_out, bus_a.count);
    else passes++;
    tick();
    bus_a.out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    drive_a(1'b0, 12'h000, 1'b0);
    bus_a.clear     = 1'b0;
    bus_a.out_ready = 1'b0;
    bus_b.in_valid  = 1'b0;
    bus_b.in_sum    = 12'h000;
    bus_b.in_cout   = 1'b0;
    bus_b.clear     = 1'b0;
    bus_b.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_hold();
    test_max();
    test_clear();
    test_rst_done();
    test_ovf();
    test_back_to_back();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
